// File: rtl/push_debouncer_pkg.sv
// push_debouncer_pkg: shared state encodings and button level constants for the push-button debouncer.
package push_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_REL   = 2'd0,
        ST_PWAIT = 2'd1,
        ST_PRS   = 2'd2,
        ST_RWAIT = 2'd3
    } state_t;

    localparam logic BTN_RELEASED = 1'b1;

endpackage

// File: rtl/push_debouncer_debounce_ch.sv
// debounce_ch: one button channel - two-flop synchroniser, qualification FSM with counter, level and strobes.
module debounce_ch
    import push_debouncer_pkg::*;
#(
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 19
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Push,
    output logic o_Push,
    output logic o_Press,
    output logic o_Release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1, s2;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             push_nx, press_nx, release_nx;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            s1        <= BTN_RELEASED;
            s2        <= BTN_RELEASED;
            state     <= ST_REL;
            cnt       <= '0;
            o_Push    <= BTN_RELEASED;
            o_Press   <= 1'b0;
            o_Release <= 1'b0;
        end else begin
            s1        <= i_Push;
            s2        <= s1;
            state     <= state_nx;
            cnt       <= cnt_nx;
            o_Push    <= push_nx;
            o_Press   <= press_nx;
            o_Release <= release_nx;
        end
    end

    // Any opposite sample during a wait state drops back and restarts from zero
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        case (state)
            ST_REL: begin
                if (s2 != BTN_RELEASED) begin
                    state_nx = ST_PWAIT;
                    cnt_nx   = CNT_ONE;
                end
            end
            ST_PWAIT: begin
                if (s2 == BTN_RELEASED)  state_nx = ST_REL;
                else if (cnt == CNT_LAST) state_nx = ST_PRS;
                else                      cnt_nx   = cnt + CNT_ONE;
            end
            ST_PRS: begin
                if (s2 == BTN_RELEASED) begin
                    state_nx = ST_RWAIT;
                    cnt_nx   = CNT_ONE;
                end
            end
            default: begin
                if (s2 != BTN_RELEASED)  state_nx = ST_PRS;
                else if (cnt == CNT_LAST) state_nx = ST_REL;
                else                      cnt_nx   = cnt + CNT_ONE;
            end
        endcase
    end

    always_comb begin
        push_nx    = (state_nx == ST_REL) || (state_nx == ST_PWAIT);
        press_nx   = (state == ST_PWAIT) && (state_nx == ST_PRS);
        release_nx = (state == ST_RWAIT) && (state_nx == ST_REL);
    end

endmodule

// File: rtl/push_debouncer.sv
// push_debouncer: NUM_BTN independent debounce channels conditioning active-low push-buttons.
module push_debouncer
    import push_debouncer_pkg::*;
#(
    parameter int NUM_BTN    = 2,
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 19
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [NUM_BTN-1:0] i_Push,
    output logic [NUM_BTN-1:0] o_Push,
    output logic [NUM_BTN-1:0] o_Press,
    output logic [NUM_BTN-1:0] o_Release
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_ch #(
            .DEB_CYCLES(DEB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_ch (
            .i_Clk    (i_Clk),
            .i_Rst    (i_Rst),
            .i_Push   (i_Push[i]),
            .o_Push   (o_Push[i]),
            .o_Press  (o_Press[i]),
            .o_Release(o_Release[i])
        );
    end

endmodule

// File: tb/tb_push_debouncer.sv
// tb_push_debouncer: randomized and directed stimulus checked by a queued reference-model scoreboard.
module tb_push_debouncer;

    localparam int NB  = 2;
    localparam int DEB = 4;

    typedef struct packed {
        logic [NB-1:0] push;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
    } exp_t;

    logic          i_Clk = 1'b0;
    logic          i_Rst = 1'b1;
    logic [NB-1:0] i_Push = 2'b11;
    logic [NB-1:0] o_Push, o_Press, o_Release;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    push_debouncer #(.NUM_BTN(NB), .DEB_CYCLES(DEB), .CNT_W(3)) dut (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Push   (i_Push),
        .o_Push   (o_Push),
        .o_Press  (o_Press),
        .o_Release(o_Release)
    );

    always #5 i_Clk = ~i_Clk;

    // Reference: a level flips once DEB consecutive synchronised samples disagree with it
    initial begin
        logic [NB-1:0] samp[$];
        logic [NB-1:0] lvl;
        logic [NB-1:0] s;
        int            run[NB];
        exp_t          e;
        forever begin
            @(posedge i_Clk or posedge i_Rst);
            if (i_Rst) begin
                samp = '{2'b11, 2'b11, 2'b11};
                lvl  = 2'b11;
                run  = '{0, 0};
                q.delete();
                q.push_back(exp_t'{2'b11, 2'b00, 2'b00});
            end else begin
                samp.push_back(i_Push);
                s = samp[samp.size() - 3];
                void'(samp.pop_front());
                e = '0;
                for (int b = 0; b < NB; b++) begin
                    if (s[b] != lvl[b]) begin
                        run[b]++;
                        if (run[b] == DEB) begin
                            lvl[b] = ~lvl[b];
                            run[b] = 0;
                            if (lvl[b]) e.rel[b] = 1'b1;
                            else        e.press[b] = 1'b1;
                        end
                    end else begin
                        run[b] = 0;
                    end
                end
                e.push = lvl;
                q.push_back(e);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge i_Clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if ({o_Push, o_Press, o_Release} !== e) begin
                    n_err++;
                    $display("FAIL scoreboard t=%0t got push=%b press=%b rel=%b, want push=%b press=%b rel=%b",
                             $time, o_Push, o_Press, o_Release, e.push, e.press, e.rel);
                end
                if (q.size() > 1) begin
                    n_err++;
                    $display("FAIL queue_lag t=%0t depth=%0d want<=1", $time, q.size());
                end
            end
        end
    end

    task automatic drive(input logic [NB-1:0] v, input int n);
        i_Push = v;
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic rst_pulse(input int n);
        #1 i_Rst = 1'b1;
        #1;
        n_vec++;
        if ({o_Push, o_Press, o_Release} !== 6'b110000) begin
            n_err++;
            $display("FAIL reset_immediate t=%0t got push=%b press=%b rel=%b, want push=11 press=00 rel=00",
                     $time, o_Push, o_Press, o_Release);
        end
        repeat (n) @(posedge i_Clk);
        #1 i_Rst = 1'b0;
    endtask

    initial begin
        logic [NB-1:0] v;
        repeat (3) @(posedge i_Clk);
        #1 i_Rst = 1'b0;
        drive(2'b00, 2);
        rst_pulse(2);
        drive(2'b00, 10);
        drive(2'b11, 10);
        drive(2'b10, 10);
        drive(2'b11, 10);
        drive(2'b10, 1); drive(2'b11, 1); drive(2'b10, 1); drive(2'b11, 1);
        drive(2'b10, 10);
        drive(2'b11, 3);
        drive(2'b10, 8);
        drive(2'b11, 10);
        drive(2'b00, 10);
        drive(2'b10, 10);
        drive(2'b11, 10);
        drive(2'b10, 3);
        rst_pulse(2);
        drive(2'b10, 10);
        drive(2'b11, 10);
        v = 2'b11;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < NB; b++)
                if ($urandom_range(0, 3) == 0) v[b] = ~v[b];
            if ($urandom_range(0, 199) == 0) rst_pulse($urandom_range(1, 3));
            drive(v, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : 1);
        end
        drive(2'b11, 10);
        @(negedge i_Clk);
        @(negedge i_Clk);
        n_vec++;
        if (n_vec < 500) begin
            n_err++;
            $display("FAIL vector_count got=%0d want>=500", n_vec);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
